// File: rtl/gcd_ctrl.sv
// Sequencing controller for the subtractive GCD datapath: accepts an operand pair,
// steps an external registered subtractor until the operands match, returns the result.
module gcd_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy,
    output logic [1:0]       sub_cmd,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_aout,
    input  logic [WIDTH-1:0] sub_bout
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] CMD_A_MINUS_B = 2'b00;
    localparam logic [1:0] CMD_B_MINUS_A = 2'b01;
    localparam logic [1:0] CMD_HOLD      = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_a_q, cur_a_d;
    logic [WIDTH-1:0]   cur_b_q, cur_b_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_gcd_q, out_gcd_d;
    logic               out_err_q, out_err_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_a_q     <= '0;
            cur_b_q     <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_a_q     <= cur_a_d;
            cur_b_q     <= cur_b_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
            out_gcd_q   <= out_gcd_d;
            out_err_q   <= out_err_d;
        end
    end

    // Next-state and subtractor command decode
    always_comb begin
        state_d     = state_q;
        cur_a_d     = cur_a_q;
        cur_b_d     = cur_b_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;
        out_gcd_d   = out_gcd_q;
        out_err_d   = out_err_q;
        sub_cmd     = CMD_HOLD;
        sub_a       = cur_a_q;
        sub_b       = cur_b_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_a == '0 || in_b == '0) begin
                        // Zero operands bypass the subtractor entirely
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_gcd_d   = in_a | in_b;
                        out_err_d   = (in_a == '0) && (in_b == '0);
                    end else begin
                        state_d = CALC;
                        cur_a_d = in_a;
                        cur_b_d = in_b;
                        iter_d  = '0;
                    end
                end
            end
            CALC: begin
                if (cur_a_q == cur_b_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_gcd_d   = cur_a_q;
                    out_err_d   = 1'b0;
                end else if (iter_q == CNT_W'(MAX_ITER)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_gcd_d   = '0;
                    out_err_d   = 1'b1;
                end else begin
                    sub_cmd = (cur_a_q > cur_b_q) ? CMD_A_MINUS_B : CMD_B_MINUS_A;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = CALC;
                cur_a_d = sub_aout;
                cur_b_d = sub_bout;
                iter_d  = (iter_q == '1) ? iter_q : iter_q + CNT_W'(1);
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_gcd   = out_gcd_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Randomized self-checking bench for gcd_ctrl with a behavioural subtractor and a
// plain-arithmetic GCD reference model.
module tb_gcd_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    // Default instance (MAX_ITER = 255)
    logic         in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [W-1:0] in_a, in_b, out_gcd, sub_a, sub_b, sub_aout, sub_bout;
    logic [1:0]   sub_cmd;

    // Small iteration-limit instance (MAX_ITER = 3)
    logic         in_valid2, in_ready2, out_valid2, out_ready2, out_err2, busy2;
    logic [W-1:0] in_a2, in_b2, out_gcd2, sub_a2, sub_b2, sub_aout2, sub_bout2;
    logic [1:0]   sub_cmd2;

    gcd_ctrl #(.WIDTH(W), .MAX_ITER(255)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
        .busy(busy), .sub_cmd(sub_cmd), .sub_a(sub_a), .sub_b(sub_b),
        .sub_aout(sub_aout), .sub_bout(sub_bout)
    );

    gcd_ctrl #(.WIDTH(W), .MAX_ITER(3)) dut_lim (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_gcd(out_gcd2), .out_err(out_err2),
        .busy(busy2), .sub_cmd(sub_cmd2), .sub_a(sub_a2), .sub_b(sub_b2),
        .sub_aout(sub_aout2), .sub_bout(sub_bout2)
    );

    // Registered subtractors driven by each controller
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_aout <= '0;
            sub_bout <= '0;
        end else if (sub_cmd == 2'b00) begin
            sub_aout <= sub_a - sub_b;
            sub_bout <= sub_b;
        end else if (sub_cmd == 2'b01) begin
            sub_aout <= sub_a;
            sub_bout <= sub_b - sub_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_aout2 <= '0;
            sub_bout2 <= '0;
        end else if (sub_cmd2 == 2'b00) begin
            sub_aout2 <= sub_a2 - sub_b2;
            sub_bout2 <= sub_b2;
        end else if (sub_cmd2 == 2'b01) begin
            sub_aout2 <= sub_a2;
            sub_bout2 <= sub_b2 - sub_a2;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cmds[$];
    int got_cmds[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference: result, error flag, edges from accept edge to out_valid rising, command list
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input int max_iter,
                         output logic [W-1:0] g, output logic e, output int lat);
        int x, y, n, t;
        exp_cmds.delete();
        g   = '0;
        e   = 1'b0;
        lat = 0;
        if (a == 0 && b == 0) begin
            e = 1'b1;
        end else if (a == 0 || b == 0) begin
            g = (a == 0) ? b : a;
        end else begin
            x = int'(a);
            y = int'(b);
            n = 0;
            while (x != y && n < max_iter) begin
                if (x > y) begin
                    exp_cmds.push_back(0);
                    x = x - y;
                end else begin
                    exp_cmds.push_back(1);
                    y = y - x;
                end
                n++;
            end
            lat = 2 * n + 1;
            if (x != y) begin
                e = 1'b1;
            end else begin
                x = int'(a);
                y = int'(b);
                while (y != 0) begin
                    t = x % y;
                    x = y;
                    y = t;
                end
                g = W'(x);
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < got_cmds.size() && i < exp_cmds.size(); i++)
            if (got_cmds[i] != exp_cmds[i]) return i;
        return -1;
    endfunction

    // One job on the default instance, with optional backpressure and busy-time junk input
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input bit junk);
        logic [W-1:0] g;
        logic         e;
        int           lat_exp, lat, guard;
        model(a, b, 255, g, e, lat_exp);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        got_cmds.delete();
        lat = 0;
        while (!out_valid && lat < 1000) begin
            if (sub_cmd != 2'b10) got_cmds.push_back(int'(sub_cmd));
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(lat_exp));
        check("gcd", 32'(out_gcd), 32'(g));
        check("err", 32'(out_err), 32'(e));
        check("cmd_count", 32'(got_cmds.size()), 32'(exp_cmds.size()));
        check("cmd_first_diff", 32'(first_diff()), 32'(-1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_gcd", 32'(out_gcd), 32'(g));
            check("hold_err", 32'(out_err), 32'(e));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] g;
        logic         e;
        int           lat_exp, lat;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_gcd", 32'(out_gcd), 32'd0);
        check("rst_sub_cmd", 32'(sub_cmd), 32'd2);
        check("rst_sub_a", 32'(sub_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed cases
        run_job(8'd12, 8'd8, 0, 1'b0);
        run_job(8'd255, 8'd1, 0, 1'b0);
        run_job(8'd0, 8'd9, 0, 1'b0);
        run_job(8'd7, 8'd0, 0, 1'b0);
        run_job(8'd0, 8'd0, 0, 1'b0);
        run_job(8'd5, 8'd5, 0, 1'b0);
        run_job(8'd18, 8'd12, 10, 1'b1);
        run_job(8'd9, 8'd6, 0, 1'b0);

        // Reset while waiting on the subtractor
        in_a = 8'd100; in_b = 8'd75; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_calc_cmd", 32'(sub_cmd), 32'd0);
        @(negedge clk);
        check("mid_wait_cmd", 32'(sub_cmd), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cmd", 32'(sub_cmd), 32'd2);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(in_ready), 32'd1);
        run_job(8'd100, 8'd75, 0, 1'b0);

        // Iteration limit instance
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? 8'd255 : 8'd12;
            rb = (k == 0) ? 8'd1 : 8'd8;
            model(ra, rb, 3, g, e, lat_exp);
            in_a2 = ra; in_b2 = rb; in_valid2 = 1'b1; out_ready2 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("lim_latency", 32'(lat), 32'(lat_exp));
            check("lim_gcd", 32'(out_gcd2), 32'(g));
            check("lim_err", 32'(out_err2), 32'(e));
            out_ready2 = 1'b1;
            @(negedge clk);
            out_ready2 = 1'b0;
            check("lim_post_valid", 32'(out_valid2), 32'd0);
            @(negedge clk);
        end

        // Random nonzero pairs with random backpressure and busy-time input noise
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom_range(1, 255));
            rb = W'($urandom_range(1, 255));
            run_job(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
